// File: rtl/datapath.sv
// datapath: register/ALU/RAM datapath driven by the microcode sequencer's control word.
// Latency: bus and ALU are combinational; every register, flag, PC and RAM update is visible 1 cycle later.
// Backpressure: none; the control word is obeyed every cycle, and HALTED freezes state until RESET.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   HLT, CE, SU, RI            halt, PC count enable, ALU subtract, RAM write-from-bus (active high)
//   AIn..MIn                   active-low register loads (A, B, OUT, IR, PC jump, flags, MAR)
//   AOn..NOn                   active-low bus drivers, priority A > B > I > C > E > R > N
//   IN_DATA                    external input port driven onto the bus by NOn
//   PROG_WE/ADDR/DATA          external RAM loader, active in every state including reset/halt
//   OPCODE, CF, ZF             registered status back to the sequencer
//   OUT_DATA, OUT_STROBE       output register and its one-cycle load pulse
//   HALTED                     sticky halt, cleared only by RESET
//   BUS_ERR                    sticky multiple-driver flag, present only with DATAPATH_BUS_ERR_EN
//   BUS                        resolved bus value (debug)
//
// Optional feature macro: DATAPATH_BUS_ERR_EN adds the BUS_ERR output and its checker.

module datapath (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       HLT,
  input  logic       CE,
  input  logic       SU,
  input  logic       RI,
  input  logic       AIn,
  input  logic       BIn,
  input  logic       OIn,
  input  logic       IIn,
  input  logic       Jn,
  input  logic       FIn,
  input  logic       MIn,
  input  logic       AOn,
  input  logic       BOn,
  input  logic       IOn,
  input  logic       COn,
  input  logic       EOn,
  input  logic       ROn,
  input  logic       NOn,
  input  logic [7:0] IN_DATA,
  input  logic       PROG_WE,
  input  logic [3:0] PROG_ADDR,
  input  logic [7:0] PROG_DATA,
  output logic [3:0] OPCODE,
  output logic       CF,
  output logic       ZF,
  output logic [7:0] OUT_DATA,
  output logic       OUT_STROBE,
  output logic       HALTED,
`ifdef DATAPATH_BUS_ERR_EN
  output logic       BUS_ERR,
`endif
  output logic [7:0] BUS
);

  // Architectural state
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] out_q, out_d;
  logic [3:0] mar_q, mar_d;
  logic [3:0] pc_q, pc_d;
  logic       cf_q, cf_d;
  logic       zf_q, zf_d;
  logic       strobe_q, strobe_d;
  logic       halted_q, halted_d;

  // 16x8 program/data RAM; deliberately has no reset so a loaded program survives RESET
  logic [7:0] mem_q [16];

  // Combinational datapath signals
  logic [7:0] bus;
  logic [8:0] alu_sum;
  logic       alu_c;
  logic       alu_z;
  logic       upd_en;
  logic       ri_wr_en;

  // ---------------------------------------------------------------------------
  // Bus resolution: fixed priority, first active-low driver wins
  // ---------------------------------------------------------------------------
  always_comb begin
    bus = 8'h00;
    if (!AOn)      bus = a_q;
    else if (!BOn) bus = b_q;
    else if (!IOn) bus = {4'h0, ir_q[3:0]};
    else if (!COn) bus = {4'h0, pc_q};
    else if (!EOn) bus = alu_sum[7:0];
    else if (!ROn) bus = mem_q[mar_q];
    else if (!NOn) bus = IN_DATA;
  end

  // ---------------------------------------------------------------------------
  // ALU: two's-complement subtract is A + ~B + 1, so the carry out is the
  // "no borrow" flag (set when A >= B on subtract).
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_sum = {1'b0, a_q} + {1'b0, (SU ? ~b_q : b_q)} + {8'h00, SU};
    alu_c   = alu_sum[8];
    alu_z   = (alu_sum[7:0] == 8'h00);
  end

  // Once halted, only the RAM loader and RESET can change anything
  assign upd_en = ~halted_q;

  // ---------------------------------------------------------------------------
  // Next-state logic: every load samples the same-cycle bus, so a register that
  // drives and loads in the same cycle simply reloads its own value.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    ir_d     = ir_q;
    out_d    = out_q;
    mar_d    = mar_q;
    pc_d     = pc_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    strobe_d = 1'b0;
    halted_d = halted_q | HLT;

    if (upd_en) begin
      if (!AIn) a_d   = bus;
      if (!BIn) b_d   = bus;
      if (!IIn) ir_d  = bus;
      if (!MIn) mar_d = bus[3:0];
      if (!OIn) begin
        out_d    = bus;
        strobe_d = 1'b1;
      end
      if (!FIn) begin
        cf_d = alu_c;
        zf_d = alu_z;
      end
      // Jump has priority over the increment; 4-bit add wraps 15 -> 0
      if (!Jn)     pc_d = bus[3:0];
      else if (CE) pc_d = pc_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      ir_q     <= 8'h00;
      out_q    <= 8'h00;
      mar_q    <= 4'h0;
      pc_q     <= 4'h0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      strobe_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      ir_q     <= ir_d;
      out_q    <= out_d;
      mar_q    <= mar_d;
      pc_q     <= pc_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      strobe_q <= strobe_d;
      halted_q <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM writes. The loader write is placed last so it overrides an RI write
  // to the same address in the same cycle; RI is dropped during reset/halt.
  // ---------------------------------------------------------------------------
  assign ri_wr_en = RI & upd_en & ~RESET;

  always_ff @(posedge CLK) begin
    if (ri_wr_en) mem_q[mar_q] <= bus;
    if (PROG_WE)  mem_q[PROG_ADDR] <= PROG_DATA;
  end

`ifdef DATAPATH_BUS_ERR_EN
  // ---------------------------------------------------------------------------
  // Contention checker: flags any cycle with two or more drivers enabled.
  // x & (x-1) clears the lowest set bit, so it is non-zero iff >1 bit is set.
  // ---------------------------------------------------------------------------
  logic [6:0] drv_act;
  logic       multi_drv;
  logic       bus_err_q, bus_err_d;

  always_comb begin
    drv_act   = ~{AOn, BOn, IOn, COn, EOn, ROn, NOn};
    multi_drv = |(drv_act & (drv_act - 7'd1));
    bus_err_d = bus_err_q | multi_drv;
  end

  always_ff @(posedge CLK) begin
    if (RESET) bus_err_q <= 1'b0;
    else       bus_err_q <= bus_err_d;
  end

  assign BUS_ERR = bus_err_q;
`endif

  // Outputs
  assign OPCODE     = ir_q[7:4];
  assign CF         = cf_q;
  assign ZF         = zf_q;
  assign OUT_DATA   = out_q;
  assign OUT_STROBE = strobe_q;
  assign HALTED     = halted_q;
  assign BUS        = bus;

endmodule

// File: doc/datapath.md
# datapath

Register/ALU/memory datapath that sits on the receiving end of the CPU's control word: it decodes the per-step strobes issued by the microcode sequencer, resolves the shared 8-bit bus, and updates its A/B/output/instruction/address registers, program counter, flags and 16-byte RAM. It returns `OPCODE`, `CF` and `ZF` to the sequencer. The control word changes on the falling edge of `CLK`; the datapath samples it on the rising edge.

## Interface
- No parameters; bus 8 bits, address/PC 4 bits, RAM 16×8.
- `CLK` in 1: system clock; all state updates on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `HLT, CE, SU, RI` in 1 each: active-high controls.
- `AIn, BIn, OIn, IIn, Jn, FIn, MIn` in 1 each: active-low register loads.
- `AOn, BOn, IOn, COn, EOn, ROn, NOn` in 1 each: active-low bus drivers.
- `IN_DATA` in 8: external input port, driven onto the bus by `NOn`.
- `PROG_WE` in 1, `PROG_ADDR` in 4, `PROG_DATA` in 8: external RAM loader.
- `OPCODE` out 4: `IR[7:4]`.
- `CF`, `ZF` out 1 each: latched flags.
- `OUT_DATA` out 8: output register. `OUT_STROBE` out 1: one-cycle pulse when `OUT_DATA` loads.
- `HALTED` out 1: sticky halt; used externally to drop `RUN`.
- `BUS` out 8: current bus value (debug).

## Operation
- Bus source, combinational, fixed priority A > B > I > C > E > R > N:
  - `AOn`: A.
  - `BOn`: B.
  - `IOn`: `{4'h0, IR[3:0]}`.
  - `COn`: `{4'h0, PC}`.
  - `EOn`: ALU sum.
  - `ROn`: `RAM[MAR]`.
  - `NOn`: `IN_DATA`.
  - No driver active: `8'h00`.
- ALU, 9-bit: `{c, s} = A + (SU ? ~B : B) + SU`.
  - `CF` source is `c`; `SU=1` with A ≥ B gives c=1.
  - `ZF` source is `s == 0`.
- Rising-edge updates while not halted, all using the same-cycle bus:
  - `AIn` low: A ← bus.
  - `BIn` low: B ← bus.
  - `IIn` low: IR ← bus.
  - `MIn` low: MAR ← bus[3:0].
  - `OIn` low: OUT ← bus and `OUT_STROBE` = 1 next cycle; otherwise `OUT_STROBE` = 0.
  - `FIn` low: {CF, ZF} ← ALU.
  - `RI` high: `RAM[MAR]` ← bus.
- PC:
  - `Jn` low: PC ← bus[3:0].
  - Otherwise `CE` high: PC ← PC+1, wrapping 15→0.
  - `Jn` beats `CE`.
- Multiple loads in one cycle all take the same bus value. Reading and writing the same register in one cycle (e.g. `AOn`+`AIn`) is legal; the register keeps its old value.
- Halt:
  - `HLT` high at an edge sets `HALTED`.
  - While `HALTED`, all register, flag, PC and `RI` updates are suppressed.
  - `HALTED` clears only on `RESET`.
- Programming: `PROG_WE` writes `RAM[PROG_ADDR]` ← `PROG_DATA` in any state, including halted and in reset. On a same-address collision with `RI`, `PROG_WE` wins.
- Reset values: A, B, IR, MAR, PC, OUT, CF, ZF, `OUT_STROBE` and `HALTED` are all 0. RAM is not cleared. `RESET` mid-instruction discards all pending loads that cycle.

## Timing
- Bus and ALU are combinational in the cycle the control word is presented. Every register update is visible 1 cycle later.
- `OPCODE`, `CF` and `ZF` are registered. They are stable across the sequencer's falling edge.
- `OUT_STROBE` is high for exactly one cycle per `OIn` assertion. Back-to-back `OIn` gives continuous high.
- `HALTED` rises on the edge after the cycle in which `HLT` is sampled high. A load asserted in that same cycle still takes effect.

## Configuration
- `DATAPATH_BUS_ERR_EN` defined:
  - Adds output `BUS_ERR` (1 bit, reset 0).
  - `BUS_ERR` is set sticky when two or more of `AOn, BOn, IOn, COn, EOn, ROn, NOn` are low at a rising edge; it clears on `RESET`.
  - Priority resolution is unchanged.
- Undefined: no `BUS_ERR` port and no checking logic.

## Test plan
- Program `RAM[0..2]`:
  - Drive the fetch/execute control words for LDA 14 / ADD 15 / OUT, with `RAM[14]=8'h1C` and `RAM[15]=8'h0E`.
  - Required: `OUT_DATA=8'h2A`, `OUT_STROBE` pulses once, `CF=0`, `ZF=0`.
- Subtract with borrow:
  - A=5, B=7, `SU=1`, `EOn` low, `FIn` low, `AIn` low.
  - Required: A=8'hFE, `CF=0`, `ZF=0`.
  - Then A=7, B=7: A=0, `CF=1`, `ZF=1`.
- PC wrap and jump priority:
  - PC=15 with `CE`: PC=0.
  - `CE` and `Jn` together with bus=8'h09: PC=9.
- Halt:
  - Assert `HLT` together with `AIn` low, bus=8'h33: A=8'h33 and `HALTED`=1.
  - Subsequent `AIn`/`CE` cycles leave A and PC unchanged.
  - `PROG_WE` still writes.
  - `RESET`: all listed registers 0, `HALTED`=0, RAM retained.
- Collision:
  - `RI` with MAR=3 and `PROG_WE` to address 3 in the same cycle: `PROG_DATA` stored.
  - With the macro defined, `AOn` and `ROn` low together: bus = A and `BUS_ERR`=1 until `RESET`.
